// File: rtl/mux_arb_pkg.sv
// Shared types for the four-requester mux arbiter: requester count, select width, FSM state.
// No logic here, so there is no latency and no backpressure.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [SEL_W-1:0]   sel_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner pick: round-robin from last+1, or lowest index when MUX_ARB_FIXED_PRIO_EN is defined.
// Zero latency; no backpressure, it only looks at the request vector.
module rr_picker
    import mux_arb_pkg::*;
(
    input  req_vec_t req,
    input  sel_t     last,
    output sel_t     winner,
    output logic     found
);

`ifdef MUX_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    always_comb begin
        winner = '0;
        // Descending scan so the lowest set index is written last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = sel_t'(i);
            end
        end
    end
`else
    always_comb begin
        sel_t idx;
        winner = '0;
        idx    = '0;
        // Scan offsets NUM_REQ..1 so that offset 1 (the index right after last) is written last and wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = last + sel_t'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end
`endif

    assign found = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Shares one 4:1 mux between four requesters with bounded-burst grants (MUX_ARB_FIXED_PRIO_EN selects fixed priority).
// Latency: one cycle from req to gnt; a stall (out_ready low) holds the grant with no beat counted.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  req_vec_t          req,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic              out_ready,
    output req_vec_t          gnt,
    output sel_t              sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    arb_state_t state, state_nxt;
    req_vec_t   gnt_nxt;
    sel_t       sel_nxt;
    sel_t       last, last_nxt;
    logic [3:0] count, count_nxt;

    sel_t       winner;
    logic       found;
    logic       beat;
    logic       last_beat;

    rr_picker u_picker (
        .req    (req),
        .last   (last),
        .winner (winner),
        .found  (found)
    );

    assign busy      = (state == GRANT);
    assign out_valid = busy && req[sel];
    assign beat      = out_valid && out_ready;
    assign last_beat = beat && (count == 4'(MAX_BURST - 1));

    always_comb begin
        out = a;
        case (sel)
            2'd0: out = a;
            2'd1: out = b;
            2'd2: out = c;
            2'd3: out = d;
            default: out = a;
        endcase
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        last_nxt  = last;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt   = winner;
                    gnt_nxt   = req_vec_t'(1) << winner;
                    count_nxt = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A withdrawn request never produces a beat, so it releases without counting.
                if (!req[sel] || last_beat) begin
                    state_nxt = IDLE;
                    last_nxt  = sel;
                    gnt_nxt   = '0;
                    count_nxt = '0;
                end else if (beat) begin
                    count_nxt = count + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= sel_t'(NUM_REQ - 1);
            count <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            last  <= last_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: expected beats are queued as stimulus is driven and popped per handshake.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] a, b, c, d;
    logic       out_ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] out;
    logic       out_valid;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] sb [$];
    logic [1:0] dat [4];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(2), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_beats(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back({4'b0, 2'(id), dat[id]});
        end
    endtask

    // Every accepted beat is compared against the head of the scoreboard.
    always @(negedge clk) begin
        logic [7:0] exp_beat;
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() != 0) exp_beat = sb.pop_front();
            else                exp_beat = 8'hff;
            chk("beat", {4'b0, sel, out}, exp_beat);
        end
    end

    // Requester data must not move while a granted beat is stalled.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    always @(posedge clk) begin
        if (prev_stall && !rst) begin
            assert ({a, b, c, d} == prev_data) else $error("data changed during stall");
        end
        prev_stall <= !rst && out_valid && !out_ready;
        prev_data  <= {a, b, c, d};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle_cnt;
        dat[0] = 2'd2; dat[1] = 2'd1; dat[2] = 2'd3; dat[3] = 2'd0;
        a = dat[0]; b = dat[1]; c = dat[2]; d = dat[3];
        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);

        // Single requester: 4-beat burst, idle gap, regrant
        @(posedge clk); #1;
        rst = 1'b0; req = 4'b0001; out_ready = 1'b1;
        push_beats(0, 8);
        @(posedge clk); @(negedge clk);
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_sel", sel, 0);
        chk("t1_out", out, 2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t1_gap_gnt", gnt, 0);
        chk("t1_gap_busy", busy, 0);
        chk("t1_gap_valid", out_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("t1_regnt", gnt, 4'b0001);
        repeat (4) @(posedge clk);
        #1 req = 4'b0000;
        @(negedge clk);
        chk("t1_sb_empty", sb.size(), 0);

        // Full contention for 40 cycles from a fresh reset
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 8; g++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            push_beats(0, 4);
`else
            push_beats(g % 4, 4);
`endif
        end
        idle_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); @(negedge clk);
            if (!busy) idle_cnt++;
        end
        #1 req = 4'b0000;
        chk("t2_idle_cycles", idle_cnt, 8);
        chk("t2_sb_empty", sb.size(), 0);

        // Stall: requester 2 held while out_ready is low, then a full burst
        @(posedge clk); #1;
        req = 4'b0100; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t3_gnt", gnt, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(posedge clk); @(negedge clk);
            end
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_out", out, 3);
            chk("t3_stall_gnt", gnt, 4'b0100);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push_beats(2, 4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t3_release_gnt", gnt, 0);
        #1 req = 4'b0000;
        chk("t3_sb_empty", sb.size(), 0);

        // Withdraw after 2 beats, then pending 1001 picks the next requester
        @(posedge clk); #1;
        req = 4'b0010;
        push_beats(1, 2);
`ifdef MUX_ARB_FIXED_PRIO_EN
        push_beats(0, 4);
`else
        push_beats(3, 4);
`endif
        @(posedge clk); @(negedge clk);
        chk("t4_gnt", gnt, 4'b0010);
        repeat (2) @(posedge clk);
        #1 req = 4'b1001;
        @(negedge clk);
        chk("t4_withdraw_valid", out_valid, 0);
        @(posedge clk); @(negedge clk);
        chk("t4_release_gnt", gnt, 0);
        @(posedge clk); @(negedge clk);
`ifdef MUX_ARB_FIXED_PRIO_EN
        chk("t4_next_gnt", gnt, 4'b0001);
`else
        chk("t4_next_gnt", gnt, 4'b1000);
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 req = 4'b0000;
        chk("t4_sb_empty", sb.size(), 0);

        // Reset during the third beat aborts the grant
        @(posedge clk); #1;
        req = 4'b1111;
        push_beats(0, 2);
        @(posedge clk); @(negedge clk);
        chk("t5_gnt", gnt, 4'b0001);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_valid", out_valid, 0);
        #1 rst = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("t5_regnt", gnt, 4'b0001);
        chk("t5_sb_empty", sb.size(), 0);
        #1 rst = 1'b1; req = 4'b0000;
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
